// File: rtl/pipe_stage_chain.sv
// Parametrised chain of PC+instruction pipeline registers with per-stage hold,
// backpressure bubbling, ranged flush and retire/kill counters.
module pipe_stage_chain #(
  parameter int NUM_STAGES = 5,
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 32,
  parameter int IDX_W      = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [PC_W-1:0]                  in_pc,
  input  logic [DATA_W-1:0]                in_instr,
  output logic                             in_ready,
  input  logic [NUM_STAGES-1:0]            hold,
  input  logic                             flush_en,
  input  logic [IDX_W-1:0]                 flush_upto,
  output logic [NUM_STAGES-1:0]            stage_valid,
  output logic [NUM_STAGES*PC_W-1:0]       stage_pc,
  output logic [NUM_STAGES*DATA_W-1:0]     stage_instr,
  output logic                             retire_valid,
  output logic [PC_W-1:0]                  retire_pc,
  output logic [DATA_W-1:0]                retire_instr,
  output logic [$clog2(NUM_STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]                 retired_cnt,
  output logic [CNT_W-1:0]                 killed_cnt
);

  localparam int                OCC_W    = $clog2(NUM_STAGES+1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_STAGES-1);

  logic [NUM_STAGES-1:0] r_valid;
  logic [PC_W-1:0]       r_pc    [NUM_STAGES];
  logic [DATA_W-1:0]     r_instr [NUM_STAGES];
  logic [CNT_W-1:0]      r_retired_cnt;
  logic [CNT_W-1:0]      r_killed_cnt;

  logic [NUM_STAGES-1:0] w_blocked;
  logic [NUM_STAGES-1:0] w_inc;
  logic [NUM_STAGES-1:0] w_kill_zone;
  logic [NUM_STAGES-1:0] w_bubble_zone;
  logic [NUM_STAGES-1:0] w_load;
  logic [IDX_W-1:0]      w_f;
  logic [CNT_W-1:0]      w_kill;

  // A running scalar walks the chain top-down so the vector never feeds itself.
  always_comb begin : blk_chain
    logic b;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_blocked = '0;
    b = hold[NUM_STAGES-1];
    w_blocked[NUM_STAGES-1] = b;
    for (int k = NUM_STAGES-2; k >= 0; k--) begin
      b = hold[k] | (r_valid[k] & b);
      w_blocked[k] = b;
    end
  end

  assign in_ready = ~w_blocked[0] & ~flush_en;
  assign w_f      = (flush_upto >= LAST_IDX) ? LAST_IDX : flush_upto;

  always_comb begin
    w_inc         = '0;
    w_kill_zone   = '0;
    w_bubble_zone = '0;
    w_load        = '0;
    w_kill        = '0;
    w_inc[0] = in_valid & in_ready;
    for (int k = 1; k < NUM_STAGES; k++)
      w_inc[k] = r_valid[k-1] & ~w_blocked[k-1];
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_kill_zone[k]   = flush_en & (k <= int'(w_f));
      w_bubble_zone[k] = flush_en & (k == int'(w_f) + 1);
      w_load[k]        = ~w_blocked[k] & w_inc[k] & ~w_kill_zone[k] & ~w_bubble_zone[k];
      if (w_kill_zone[k] & r_valid[k])
        w_kill = w_kill + CNT_W'(1);
      if (w_bubble_zone[k] & ~w_blocked[k] & w_inc[k])
        w_kill = w_kill + CNT_W'(1);
    end
  end

  assign retire_valid = r_valid[NUM_STAGES-1] & ~hold[NUM_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid       <= '0;
      // NOTE: the data arrays are reset too, because stage PC/instr must read zero after reset.
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_pc[k]    <= '0;
        r_instr[k] <= '0;
      end
      r_retired_cnt <= '0;
      r_killed_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (w_kill_zone[k])
          r_valid[k] <= 1'b0;
        else if (!w_blocked[k])
          r_valid[k] <= w_inc[k] & ~w_bubble_zone[k];
      end
      if (w_load[0]) begin
        r_pc[0]    <= in_pc;
        r_instr[0] <= in_instr;
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (w_load[k]) begin
          r_pc[k]    <= r_pc[k-1];
          r_instr[k] <= r_instr[k-1];
        end
      end
      r_retired_cnt <= r_retired_cnt + CNT_W'(retire_valid);
      r_killed_cnt  <= r_killed_cnt + w_kill;
    end
  end

  always_comb begin
    stage_pc    = '0;
    stage_instr = '0;
    occupancy   = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_pc[k*PC_W +: PC_W]        = r_pc[k];
      stage_instr[k*DATA_W +: DATA_W] = r_instr[k];
      occupancy = occupancy + OCC_W'(r_valid[k]);
    end
  end

  assign stage_valid  = r_valid;
  assign retire_pc    = r_pc[NUM_STAGES-1];
  assign retire_instr = r_instr[NUM_STAGES-1];
  assign retired_cnt  = r_retired_cnt;
  assign killed_cnt   = r_killed_cnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus random traffic
// compared against an entry-movement reference model.
module tb_pipe_stage_chain;

  localparam int N = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid;
  logic [31:0]     in_pc, in_instr;
  logic            in_ready;
  logic [N-1:0]    hold;
  logic            flush_en;
  logic [2:0]      flush_upto;
  logic [N-1:0]    stage_valid;
  logic [N*32-1:0] stage_pc, stage_instr;
  logic            retire_valid;
  logic [31:0]     retire_pc, retire_instr;
  logic [2:0]      occupancy;
  logic [31:0]     retired_cnt, killed_cnt;

  always #5 clk = ~clk;

  pipe_stage_chain dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .hold(hold), .flush_en(flush_en), .flush_upto(flush_upto),
    .stage_valid(stage_valid), .stage_pc(stage_pc), .stage_instr(stage_instr),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .occupancy(occupancy), .retired_cnt(retired_cnt), .killed_cnt(killed_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a set of entries that each either stay put, move up one slot,
  // or leave the top; a flush removes every entry currently sitting in slots 0..F.
  bit          m_v   [N];
  logic [31:0] m_pc  [N];
  logic [31:0] m_ins [N];
  logic [31:0] m_ret, m_kill;
  bit          mv    [N];
  bit          room  [N];
  bit          e_rdy;
  int          cyc, acc_cyc, ret_cyc;
  logic [31:0] next_pc;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_v[k] = 1'b0; m_pc[k] = '0; m_ins[k] = '0;
    end
    m_ret = '0; m_kill = '0;
  endfunction

  function automatic void model_comb();
    for (int k = N-1; k >= 0; k--) begin
      if (k == N-1) mv[k] = m_v[k] && !hold[k];
      else          mv[k] = m_v[k] && !hold[k] && room[k+1];
      room[k] = !hold[k] && (!m_v[k] || mv[k]);
    end
    e_rdy = room[0] && !flush_en;
  endfunction

  function automatic void model_next();
    bit          n_v   [N];
    logic [31:0] n_pc  [N];
    logic [31:0] n_ins [N];
    int f, kills, dest;
    f     = (int'(flush_upto) > N-1) ? N-1 : int'(flush_upto);
    kills = 0;
    for (int k = 0; k < N; k++) begin
      n_v[k] = 1'b0; n_pc[k] = '0; n_ins[k] = '0;
    end
    if (mv[N-1]) m_ret = m_ret + 1;
    for (int k = 0; k < N; k++) begin
      if (m_v[k]) begin
        dest = mv[k] ? k + 1 : k;
        if (flush_en && k <= f) begin
          kills++;
          if (mv[k] && k == f && k < N-1) kills++;
        end else if (dest < N) begin
          n_v[dest] = 1'b1; n_pc[dest] = m_pc[k]; n_ins[dest] = m_ins[k];
        end
      end
    end
    if (in_valid && e_rdy) begin
      n_v[0] = 1'b1; n_pc[0] = in_pc; n_ins[0] = in_instr;
    end
    if (flush_en) m_kill = m_kill + 32'(kills);
    for (int k = 0; k < N; k++) begin
      m_v[k] = n_v[k]; m_pc[k] = n_pc[k]; m_ins[k] = n_ins[k];
    end
  endfunction

  task automatic drive(input bit v);
    in_valid = v;
    in_pc    = next_pc;
    in_instr = next_pc ^ 32'hA5A5_0000;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    logic [N-1:0] ev;
    int occ;
    #1;
    model_comb();
    occ = 0;
    for (int k = 0; k < N; k++) occ += int'(m_v[k]);
    check({tag, ":in_ready"}, in_ready, e_rdy);
    check({tag, ":occupancy"}, occupancy, occ);
    check({tag, ":retire_valid"}, retire_valid, mv[N-1]);
    if (m_v[N-1]) begin
      check({tag, ":retire_pc"}, retire_pc, m_pc[N-1]);
      check({tag, ":retire_instr"}, retire_instr, m_ins[N-1]);
    end
    if (in_valid && e_rdy && acc_cyc < 0) acc_cyc = cyc;
    if (retire_valid === 1'b1 && ret_cyc < 0) ret_cyc = cyc;
    if (in_valid && e_rdy) next_pc = next_pc + 32'd4;
    model_next();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < N; k++) ev[k] = m_v[k];
    check({tag, ":stage_valid"}, stage_valid, ev);
    for (int k = 0; k < N; k++) begin
      if (m_v[k]) begin
        check({tag, ":stage_pc"}, stage_pc[k*32 +: 32], m_pc[k]);
        check({tag, ":stage_instr"}, stage_instr[k*32 +: 32], m_ins[k]);
      end
    end
    check({tag, ":retired_cnt"}, retired_cnt, m_ret);
    check({tag, ":killed_cnt"}, killed_cnt, m_kill);
  endtask

  initial begin
    logic [31:0] pc2;
    in_valid = 1'b0; in_pc = '0; in_instr = '0;
    hold = '0; flush_en = 1'b0; flush_upto = '0;
    model_reset();
    next_pc = '0; cyc = 0; acc_cyc = -1; ret_cyc = -1;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("reset:stage_valid", stage_valid, 0);
    check("reset:stage_pc", stage_pc, 0);
    check("reset:retired_cnt", retired_cnt, 0);
    check("reset:killed_cnt", killed_cnt, 0);
    check("reset:occupancy", occupancy, 0);
    check("reset:in_ready", in_ready, 1);
    rst = 1'b1;

    // Unobstructed stream: latency, ordering, steady occupancy
    for (int i = 0; i < 21; i++) begin
      drive(1'b1);
      step("stream");
    end
    check("stream:latency", ret_cyc - acc_cyc, 5);
    check("stream:retired16", retired_cnt, 16);
    check("stream:occ_full", occupancy, 5);

    // Freeze stage 2 for three cycles with a full pipe
    pc2 = stage_pc[2*32 +: 32];
    hold = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1);
      step("hold2");
    end
    check("hold2:stage_pc2_frozen", stage_pc[2*32 +: 32], pc2);
    hold = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1);
      step("hold2_release");
    end
    check("hold2:occ_refilled", occupancy, 5);

    // Ranged flush of stages 0..1 with a full pipe
    flush_en = 1'b1; flush_upto = 3'd1;
    drive(1'b1);
    step("flush1");
    check("flush1:killed", killed_cnt, 3);
    check("flush1:stage_valid", stage_valid, 5'b11000);
    flush_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1);
      step("flush1_after");
    end
    check("flush1:occ_refilled", occupancy, 5);

    // Full flush (flush_upto beyond last stage) while stage 0 is held
    flush_en = 1'b1; flush_upto = 3'd7; hold = 5'b00001;
    drive(1'b1);
    step("flushall");
    check("flushall:stage_valid", stage_valid, 0);
    check("flushall:killed", killed_cnt, 8);
    flush_en = 1'b0; hold = '0;

    // Random traffic
    for (int i = 0; i < 250; i++) begin
      drive(($urandom % 4) != 0);
      in_instr = $urandom;
      for (int k = 0; k < N; k++) hold[k] = (($urandom % 5) == 0);
      flush_en   = (($urandom % 12) == 0);
      flush_upto = 3'($urandom % 8);
      step("random");
    end
    hold = '0; flush_en = 1'b0; in_valid = 1'b0;

    // Asynchronous reset pulse between clock edges
    #1 rst = 1'b0;
    #1;
    check("midreset:stage_valid", stage_valid, 0);
    check("midreset:retired_cnt", retired_cnt, 0);
    check("midreset:killed_cnt", killed_cnt, 0);
    check("midreset:occupancy", occupancy, 0);
    #1 rst = 1'b1;
    model_reset();
    acc_cyc = -1; ret_cyc = -1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1);
      step("post_reset");
    end
    check("post_reset:latency", ret_cyc - acc_cyc, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
